// File: rtl/dsram_arbiter_pkg.sv
// Shared constants and types for the data-SRAM arbiter: port indices,
// parameter defaults and the packed SRAM command used by the output mux.
package dsram_arbiter_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned CNT_W_DEF        = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
    } sram_cmd_t;

    localparam sram_cmd_t SRAM_IDLE = '0;

endpackage

// File: rtl/dsram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data SRAM pins.
// master = requesters plus SRAM environment, slave = the arbiter itself.
interface dsram_arbiter_if;

    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wen;
    logic        m0_gnt;
    logic [31:0] m0_rdata;
    logic        m0_rvalid;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wen;
    logic        m1_gnt;
    logic [31:0] m1_rdata;
    logic        m1_rvalid;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output m0_req, m0_addr, m0_wdata, m0_wen,
        input  m0_gnt, m0_rdata, m0_rvalid,
        output m1_req, m1_addr, m1_wdata, m1_wen,
        input  m1_gnt, m1_rdata, m1_rvalid,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );

    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_wen,
        output m0_gnt, m0_rdata, m0_rvalid,
        input  m1_req, m1_addr, m1_wdata, m1_wen,
        output m1_gnt, m1_rdata, m1_rvalid,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

endinterface

// File: rtl/dsram_rd_tracker.sv
// Remembers who issued the read granted last cycle and steers the
// single-cycle rvalid strobe back to that requester.
module dsram_rd_tracker
    import dsram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rd_fire_i,
    input  logic rd_port_i,
    output logic m0_rvalid_o,
    output logic m1_rvalid_o
);

    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;

    always_comb begin
        rd_pend_d  = rd_fire_i;
        rd_owner_d = rd_fire_i ? rd_port_i : rd_owner_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= PORT_CPU;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Strobes are forced low while reset is held so no stale return leaks out.
    assign m0_rvalid_o = !reset && rd_pend_q && (rd_owner_q == PORT_CPU);
    assign m1_rvalid_o = !reset && rd_pend_q && (rd_owner_q == PORT_AUX);

endmodule

// File: rtl/dsram_arbiter.sv
// Fixed-priority (CPU first) arbiter for the single-ported data SRAM, with a
// starvation counter that forces a port-1 grant after a bounded wait.
module dsram_arbiter
    import dsram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    dsram_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             force1;
    logic             m0_gnt, m1_gnt, any_gnt;
    logic             rd_fire, rd_port;
    sram_cmd_t        m0_cmd, m1_cmd, sram_cmd;

    // Requests are ignored while reset is held, so nothing reaches the SRAM.
    assign force1  = bus.m1_req && (starve_cnt_q == LIMIT);
    assign m1_gnt  = !reset && bus.m1_req && (!bus.m0_req || force1);
    assign m0_gnt  = !reset && bus.m0_req && !m1_gnt;
    assign any_gnt = m0_gnt || m1_gnt;

    assign m0_cmd = '{addr: bus.m0_addr, wdata: bus.m0_wdata, wen: bus.m0_wen};
    assign m1_cmd = '{addr: bus.m1_addr, wdata: bus.m1_wdata, wen: bus.m1_wen};

    always_comb begin
        // NOTE: default assignment first so every path drives sram_cmd and no latch is inferred.
        sram_cmd = SRAM_IDLE;
        if (m1_gnt) begin
            sram_cmd = m1_cmd;
        end else if (m0_gnt) begin
            sram_cmd = m0_cmd;
        end
    end

    assign bus.m0_gnt          = m0_gnt;
    assign bus.m1_gnt          = m1_gnt;
    assign bus.data_sram_en    = any_gnt;
    assign bus.data_sram_wen   = sram_cmd.wen;
    assign bus.data_sram_addr  = sram_cmd.addr;
    assign bus.data_sram_wdata = sram_cmd.wdata;

    // Counts consecutive denied cycles of a pending port-1 request, saturating.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (m1_gnt || !bus.m1_req) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign rd_fire = any_gnt && (sram_cmd.wen == 4'h0);
    assign rd_port = m1_gnt ? PORT_AUX : PORT_CPU;

    dsram_rd_tracker u_rd_tracker (
        .clk         (clk),
        .reset       (reset),
        .rd_fire_i   (rd_fire),
        .rd_port_i   (rd_port),
        .m0_rvalid_o (bus.m0_rvalid),
        .m1_rvalid_o (bus.m1_rvalid)
    );

    // Read data is broadcast; only the rvalid strobe identifies the owner.
    assign bus.m0_rdata = bus.data_sram_rdata;
    assign bus.m1_rdata = bus.data_sram_rdata;

endmodule

// File: tb/tb_dsram_arbiter.sv
// Self-checking bench for dsram_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_dsram_arbiter;
    import dsram_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dsram_arbiter_if bus ();

    dsram_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural SRAM driven by the DUT pins, 256 words indexed by addr[9:2].
    logic [31:0] sram_mem [256];
    logic [31:0] sram_w;
    always @(posedge clk) begin
        if (bus.data_sram_en) begin
            if (bus.data_sram_wen == 4'h0) begin
                bus.data_sram_rdata <= sram_mem[bus.data_sram_addr[9:2]];
            end else begin
                sram_w = sram_mem[bus.data_sram_addr[9:2]];
                for (int b = 0; b < 4; b++)
                    if (bus.data_sram_wen[b]) sram_w[8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
                sram_mem[bus.data_sram_addr[9:2]] <= sram_w;
            end
        end
    end

    // Reference model state: memory image, denied-cycle count, expected return.
    logic [31:0] shadow [256];
    int          waited;
    bit          rv_pend;
    bit          rv_owner;
    logic [31:0] rv_data;
    logic        obs_g0, obs_g1, obs_rv1;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive0(input bit req, input logic [31:0] addr, input logic [3:0] wen,
                          input logic [31:0] wdata);
        bus.m0_req = req; bus.m0_addr = addr; bus.m0_wen = wen; bus.m0_wdata = wdata;
    endtask

    task automatic drive1(input bit req, input logic [31:0] addr, input logic [3:0] wen,
                          input logic [31:0] wdata);
        bus.m1_req = req; bus.m1_addr = addr; bus.m1_wen = wen; bus.m1_wdata = wdata;
    endtask

    // One clock: check outputs mid-cycle against the model, advance the model, step the edge.
    task automatic cycle();
        logic        e_g0, e_g1, e_rv0, e_rv1;
        logic [31:0] e_addr, e_wdata, w;
        logic [3:0]  e_wen;
        logic [7:0]  idx;
        @(negedge clk);
        e_g1 = !reset && bus.m1_req && (!bus.m0_req || waited >= LIMIT);
        e_g0 = !reset && bus.m0_req && !e_g1;
        e_addr = '0; e_wdata = '0; e_wen = '0;
        if (e_g1) begin
            e_addr = bus.m1_addr; e_wdata = bus.m1_wdata; e_wen = bus.m1_wen;
        end else if (e_g0) begin
            e_addr = bus.m0_addr; e_wdata = bus.m0_wdata; e_wen = bus.m0_wen;
        end
        check("m0_gnt", bus.m0_gnt, e_g0);
        check("m1_gnt", bus.m1_gnt, e_g1);
        check("sram_en", bus.data_sram_en, e_g0 | e_g1);
        check("sram_wen", bus.data_sram_wen, e_wen);
        check("sram_addr", bus.data_sram_addr, e_addr);
        check("sram_wdata", bus.data_sram_wdata, e_wdata);
        e_rv0 = !reset && rv_pend && !rv_owner;
        e_rv1 = !reset && rv_pend && rv_owner;
        check("m0_rvalid", bus.m0_rvalid, e_rv0);
        check("m1_rvalid", bus.m1_rvalid, e_rv1);
        if (e_rv0) check("m0_rdata", bus.m0_rdata, rv_data);
        if (e_rv1) check("m1_rdata", bus.m1_rdata, rv_data);
        obs_g0  = bus.m0_gnt;
        obs_g1  = bus.m1_gnt;
        obs_rv1 = bus.m1_rvalid;

        rv_pend = 1'b0;
        if (reset) begin
            waited = 0;
        end else begin
            if (e_g1 || !bus.m1_req) waited = 0;
            else if (waited < LIMIT) waited++;
            if (e_g0 || e_g1) begin
                idx = e_addr[9:2];
                if (e_wen == 4'h0) begin
                    rv_pend = 1'b1; rv_owner = e_g1; rv_data = shadow[idx];
                end else begin
                    w = shadow[idx];
                    for (int b = 0; b < 4; b++)
                        if (e_wen[b]) w[8*b +: 8] = e_wdata[8*b +: 8];
                    shadow[idx] = w;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit p0, p1;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
            shadow[i]   = 32'hA5000000 ^ (i * 32'h00010203);
        end
        waited = 0; rv_pend = 1'b0; rv_owner = 1'b0; rv_data = '0;

        // Reset with both requests asserted: no grant, SRAM pins idle.
        reset = 1'b1;
        drive0(1, 32'h100, 4'h0, 32'h0);
        drive1(1, 32'h104, 4'hF, 32'h1234_5678);
        cycle(); cycle();
        check("rst_gnt0", obs_g0, 1'b0);
        check("rst_gnt1", obs_g1, 1'b0);
        reset = 1'b0;
        drive0(0, 32'h0, 4'h0, 32'h0);
        drive1(0, 32'h0, 4'h0, 32'h0);
        cycle();

        // Single CPU read, data returns the following cycle.
        drive0(1, 32'h100, 4'h0, 32'h0);
        cycle();
        drive0(0, 32'h0, 4'h0, 32'h0);
        cycle();

        // Simultaneous requests: CPU wins, port-1 write goes through next cycle.
        drive0(1, 32'h108, 4'h0, 32'h0);
        drive1(1, 32'h200, 4'hF, 32'hCAFE_F00D);
        cycle();
        check("tie_m1_denied", obs_g1, 1'b0);
        drive0(0, 32'h0, 4'h0, 32'h0);
        cycle();
        check("tie_m1_later", obs_g1, 1'b1);
        drive1(0, 32'h0, 4'h0, 32'h0);
        drive0(1, 32'h200, 4'h0, 32'h0);
        cycle();
        drive0(0, 32'h0, 4'h0, 32'h0);
        cycle();

        // Starvation: continuous CPU traffic, port 1 forced through on cycle LIMIT+1, twice.
        for (int r = 0; r < 2; r++) begin
            drive0(1, 32'h300, 4'h0, 32'h0);
            drive1(1, 32'h44 + r * 4, 4'h0, 32'h0);
            n = 0;
            do begin
                cycle();
                n++;
            end while (!obs_g1 && n < 20);
            check("starve_grant_cycle", n, LIMIT + 1);
            drive1(0, 32'h0, 4'h0, 32'h0);
        end
        cycle();
        drive0(0, 32'h0, 4'h0, 32'h0);
        cycle();

        // Alternating owners on consecutive cycles.
        drive0(1, 32'h10, 4'h0, 32'h0);
        cycle();
        drive0(0, 32'h0, 4'h0, 32'h0);
        drive1(1, 32'h20, 4'h0, 32'h0);
        cycle();
        drive1(0, 32'h0, 4'h0, 32'h0);
        cycle();

        // Reset lands right after a port-1 read grant and while another is requested.
        drive1(1, 32'h24, 4'h0, 32'h0);
        cycle();
        reset = 1'b1;
        drive1(1, 32'h28, 4'h0, 32'h0);
        cycle();
        check("rst_mid_rvalid", obs_rv1, 1'b0);
        reset = 1'b0;
        drive1(0, 32'h0, 4'h0, 32'h0);
        cycle();
        check("rst_after_rvalid", obs_rv1, 1'b0);

        // Port-1 request drops after 3 denied cycles: counter restarts.
        drive0(1, 32'h30, 4'h0, 32'h0);
        drive1(1, 32'h34, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("drop_denied", obs_g1, 1'b0);
        end
        drive1(0, 32'h0, 4'h0, 32'h0);
        cycle();
        drive1(1, 32'h38, 4'h0, 32'h0);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!obs_g1 && n < 20);
        check("drop_restart_cycle", n, LIMIT + 1);
        drive0(0, 32'h0, 4'h0, 32'h0);
        drive1(0, 32'h0, 4'h0, 32'h0);
        cycle();

        // Randomized traffic; each requester holds its request until granted.
        p0 = 1'b0; p1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(199) == 0);
            if (!p0 && $urandom_range(99) < 75) begin
                p0 = 1'b1;
                drive0(1, $urandom, ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                       $urandom);
            end
            if (!p1 && $urandom_range(99) < 40) begin
                p1 = 1'b1;
                drive1(1, $urandom, ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                       $urandom);
            end
            bus.m0_req = p0;
            bus.m1_req = p1;
            cycle();
            if (obs_g0) p0 = 1'b0;
            if (obs_g1) p1 = 1'b0;
        end
        reset = 1'b0;
        drive0(0, 32'h0, 4'h0, 32'h0);
        drive1(0, 32'h0, 4'h0, 32'h0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
